// File: rtl/jogador_automatico.sv
// Autonomous memory-game player: captures the first flashed LED, then replays the
// accumulated sequence as timed button presses, appending an LFSR-chosen jogada each round.
module jogador_automatico #(
  parameter int HOLD        = 10,
  parameter int GAP         = 10,
  parameter int MAX_JOGADAS = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       habilitar,
  input  logic [3:0] leds,
  input  logic       pronto,
  output logic [3:0] botoes,
  output logic       jogando,
  output logic       fim,
  output logic [3:0] db_estado,
  output logic [3:0] db_indice,
  output logic [3:0] db_rodada
);

  localparam int TMAX = (HOLD > GAP) ? HOLD : GAP;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] CARGA_HOLD   = TW'(HOLD - 1);
  localparam logic [TW-1:0] CARGA_GAP    = TW'(GAP - 1);
  // The initial wait is one cycle longer than a normal gap.
  localparam logic [TW-1:0] CARGA_INICIO = TW'(GAP);
  localparam logic [3:0]    ULTIMA       = 4'(MAX_JOGADAS - 1);
  localparam logic [3:0]    SEMENTE      = 4'b1001;

  localparam logic [3:0] OCIOSO        = 4'd0;
  localparam logic [3:0] ESPERA_LED    = 4'd1;
  localparam logic [3:0] ESPERA_APAGA  = 4'd2;
  localparam logic [3:0] ESPERA_INICIO = 4'd3;
  localparam logic [3:0] PRESSIONA     = 4'd4;
  localparam logic [3:0] SOLTA         = 4'd5;
  localparam logic [3:0] NOVA          = 4'd6;
  localparam logic [3:0] SOLTA_NOVA    = 4'd7;
  localparam logic [3:0] FIM           = 4'd8;

  logic [3:0]    estado;
  logic [TW-1:0] timer;
  logic [3:0]    indice;
  logic [3:0]    rodada;
  logic [3:0]    lfsr;
  logic [3:0]    mem [16];

  logic [3:0] novo;
  logic       expirou;
  logic       leds_onehot;
  logic       em_jogo;
  logic       mem_we;
  logic [3:0] mem_addr;
  logic [3:0] mem_dado;

  assign novo        = 4'b0001 << lfsr[1:0];
  assign expirou     = (timer == '0);
  assign leds_onehot = (leds != 4'd0) && ((leds & (leds - 4'd1)) == 4'd0);
  assign em_jogo     = (estado >= ESPERA_INICIO) && (estado <= SOLTA_NOVA);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado <= OCIOSO;
      timer  <= '0;
      indice <= 4'd0;
      rodada <= 4'd0;
      lfsr   <= SEMENTE;
    end else if (pronto && em_jogo) begin
      estado <= FIM;
    end else begin
      case (estado)
        OCIOSO: begin
          if (habilitar) begin
            rodada <= 4'd0;
            indice <= 4'd0;
            lfsr   <= SEMENTE;
            estado <= ESPERA_LED;
          end
        end
        ESPERA_LED: begin
          if (leds_onehot) estado <= ESPERA_APAGA;
        end
        ESPERA_APAGA: begin
          if (leds == 4'd0) begin
            timer  <= CARGA_INICIO;
            estado <= ESPERA_INICIO;
          end
        end
        ESPERA_INICIO: begin
          if (expirou) begin
            indice <= 4'd0;
            timer  <= CARGA_HOLD;
            estado <= PRESSIONA;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        PRESSIONA: begin
          if (expirou) begin
            timer  <= CARGA_GAP;
            estado <= SOLTA;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        SOLTA: begin
          if (expirou) begin
            if (indice < rodada) begin
              indice <= indice + 4'd1;
              timer  <= CARGA_HOLD;
              estado <= PRESSIONA;
            end else if (rodada == ULTIMA) begin
              estado <= FIM;
            end else begin
              timer  <= CARGA_HOLD;
              estado <= NOVA;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        NOVA: begin
          if (expirou) begin
            lfsr   <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
            timer  <= CARGA_GAP;
            estado <= SOLTA_NOVA;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        SOLTA_NOVA: begin
          if (expirou) begin
            rodada <= rodada + 4'd1;
            indice <= 4'd0;
            timer  <= CARGA_HOLD;
            estado <= PRESSIONA;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        FIM: begin
          if (!habilitar) estado <= OCIOSO;
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

  // The new jogada is stored only when NOVA completes without an abort.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = 4'd0;
    mem_dado = leds;
    if (estado == ESPERA_LED && leds_onehot) begin
      mem_we = 1'b1;
    end else if (estado == NOVA && expirou && !pronto) begin
      mem_we   = 1'b1;
      mem_addr = rodada + 4'd1;
      mem_dado = novo;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_addr] <= mem_dado;
  end

  always_comb begin
    botoes = 4'd0;
    case (estado)
      PRESSIONA: botoes = mem[indice];
      NOVA:      botoes = novo;
      default:   botoes = 4'd0;
    endcase
  end

  assign jogando   = (estado >= PRESSIONA) && (estado <= SOLTA_NOVA);
  assign fim       = (estado == FIM);
  assign db_estado = estado;
  assign db_indice = indice;
  assign db_rodada = rodada;

endmodule

// File: tb/tb_jogador_automatico.sv
// Bench for jogador_automatico: a per-cycle expected trace of botoes/indice/rodada is
// built from the game rules and compared against the player in several scenarios.
module tb_jogador_automatico;

  localparam int HOLD = 10;
  localparam int GAP  = 10;
  localparam int MAXJ = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       habilitar = 1'b0;
  logic       pronto = 1'b0;
  logic [3:0] leds = 4'd0;
  logic [3:0] botoes;
  logic       jogando;
  logic       fim;
  logic [3:0] db_estado;
  logic [3:0] db_indice;
  logic [3:0] db_rodada;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] exp_b [$];
  logic [3:0] exp_i [$];
  logic [3:0] exp_r [$];

  always #5 clock = ~clock;

  jogador_automatico #(.HOLD(HOLD), .GAP(GAP), .MAX_JOGADAS(MAXJ)) dut (
    .clock(clock),
    .reset(reset),
    .habilitar(habilitar),
    .leds(leds),
    .pronto(pronto),
    .botoes(botoes),
    .jogando(jogando),
    .fim(fim),
    .db_estado(db_estado),
    .db_indice(db_indice),
    .db_rodada(db_rodada)
  );

  task automatic push_exp(input logic [3:0] b, input logic [3:0] i, input logic [3:0] r);
    exp_b.push_back(b);
    exp_i.push_back(i);
    exp_r.push_back(r);
  endtask

  // Expected trace, one entry per cycle, starting at the first edge that sees leds == 0.
  task automatic build_model(input logic [3:0] first);
    logic [3:0] seq [$];
    int lf;
    logic [3:0] nv;
    exp_b.delete();
    exp_i.delete();
    exp_r.delete();
    seq.push_back(first);
    lf = 9;
    for (int k = 0; k <= GAP; k++) push_exp(4'd0, 4'd0, 4'd0);
    for (int r = 0; r < MAXJ; r++) begin
      for (int i = 0; i <= r; i++) begin
        repeat (HOLD) push_exp(seq[i], 4'(i), 4'(r));
        repeat (GAP)  push_exp(4'd0, 4'(i), 4'(r));
      end
      if (r < MAXJ - 1) begin
        nv = 4'(1 << (lf % 4));
        repeat (HOLD) push_exp(nv, 4'(r), 4'(r));
        repeat (GAP)  push_exp(4'd0, 4'(r), 4'(r));
        seq.push_back(nv);
        lf = ((lf << 1) & 15) | (((lf >> 3) ^ (lf >> 2)) & 1);
      end
    end
  endtask

  task automatic start_game(input logic [3:0] first, input logic [3:0] noise, input int noise_cycles);
    @(negedge clock);
    habilitar = 1'b1;
    leds = noise;
    repeat (noise_cycles + 1) @(negedge clock);
    leds = first;
    repeat (50) @(negedge clock);
    leds = 4'd0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clock);
    n_cmp++;
    if (botoes !== 4'd0 || db_estado !== 4'd0) begin
      n_err++;
      $display("FAIL reset_held botoes=%b estado=%0d want 0000/0", botoes, db_estado);
    end
    reset = 1'b1;
    @(negedge clock);
    n_cmp++;
    if ({botoes, db_estado, db_indice, db_rodada, fim, jogando} !== 18'd0) begin
      n_err++;
      $display("FAIL reset_release botoes=%b estado=%0d idx=%0d rod=%0d fim=%b jog=%b want all zero",
               botoes, db_estado, db_indice, db_rodada, fim, jogando);
    end
  endtask

  task automatic test_first_rounds();
    build_model(4'b0001);
    start_game(4'b0001, 4'b0000, 0);
    for (int k = 0; k < 111; k++) begin
      @(negedge clock);
      n_cmp++;
      if (botoes !== exp_b[k] || db_indice !== exp_i[k] || db_rodada !== exp_r[k]) begin
        n_err++;
        $display("FAIL first_rounds k=%0d got b=%b i=%0d r=%0d want b=%b i=%0d r=%0d",
                 k, botoes, db_indice, db_rodada, exp_b[k], exp_i[k], exp_r[k]);
      end
      if (exp_b[k] != 4'd0) begin
        n_cmp++;
        if (jogando !== 1'b1) begin
          n_err++;
          $display("FAIL first_rounds_jogando k=%0d got %b want 1", k, jogando);
        end
      end
    end
    n_cmp++;
    if (db_rodada !== 4'd1) begin
      n_err++;
      $display("FAIL first_rounds_rodada got %0d want 1", db_rodada);
    end
  endtask

  // Continues the game left running by test_first_rounds.
  task automatic test_abort();
    int stop;
    stop = 111 + $urandom_range(0, 79);
    while (exp_b[stop] == 4'd0) stop++;
    for (int k = 111; k <= stop; k++) begin
      @(negedge clock);
      n_cmp++;
      if (botoes !== exp_b[k] || db_indice !== exp_i[k] || db_rodada !== exp_r[k]) begin
        n_err++;
        $display("FAIL abort_pre k=%0d got b=%b i=%0d r=%0d want b=%b i=%0d r=%0d",
                 k, botoes, db_indice, db_rodada, exp_b[k], exp_i[k], exp_r[k]);
      end
    end
    pronto = 1'b1;
    @(negedge clock);
    pronto = 1'b0;
    n_cmp++;
    if (botoes !== 4'd0 || fim !== 1'b1 || db_estado !== 4'd8 || jogando !== 1'b0) begin
      n_err++;
      $display("FAIL abort_fim got b=%b fim=%b estado=%0d jog=%b want 0000/1/8/0",
               botoes, fim, db_estado, jogando);
    end
    habilitar = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (db_estado !== 4'd0 || fim !== 1'b0) begin
      n_err++;
      $display("FAIL abort_ocioso got estado=%0d fim=%b want 0/0", db_estado, fim);
    end
  endtask

  task automatic test_noise_and_reset();
    int stop;
    build_model(4'b0100);
    start_game(4'b0100, 4'b0101, 20);
    stop = 51 + $urandom_range(0, HOLD - 1);
    for (int k = 0; k <= stop; k++) begin
      @(negedge clock);
      n_cmp++;
      if (botoes !== exp_b[k] || db_indice !== exp_i[k] || db_rodada !== exp_r[k]) begin
        n_err++;
        $display("FAIL noise k=%0d got b=%b i=%0d r=%0d want b=%b i=%0d r=%0d",
                 k, botoes, db_indice, db_rodada, exp_b[k], exp_i[k], exp_r[k]);
      end
    end
    #2;
    reset = 1'b0;
    habilitar = 1'b0;
    #1;
    n_cmp++;
    if (botoes !== 4'd0 || db_estado !== 4'd0 || db_indice !== 4'd0 || db_rodada !== 4'd0) begin
      n_err++;
      $display("FAIL async_reset got b=%b estado=%0d i=%0d r=%0d want all zero",
               botoes, db_estado, db_indice, db_rodada);
    end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_full_run();
    logic [3:0] first;
    logic [3:0] noise;
    int ncyc;
    int total;
    first = 4'(1 << $urandom_range(0, 3));
    noise = 4'($urandom_range(0, 15));
    while ($countones(noise) < 2) noise = 4'($urandom_range(0, 15));
    ncyc = $urandom_range(1, 20);
    build_model(first);
    total = exp_b.size();
    start_game(first, noise, ncyc);
    for (int k = 0; k < total + 3; k++) begin
      @(negedge clock);
      if (k < total) begin
        n_cmp++;
        if (botoes !== exp_b[k] || db_indice !== exp_i[k] || db_rodada !== exp_r[k]) begin
          n_err++;
          $display("FAIL full_run k=%0d got b=%b i=%0d r=%0d want b=%b i=%0d r=%0d",
                   k, botoes, db_indice, db_rodada, exp_b[k], exp_i[k], exp_r[k]);
        end
      end else begin
        n_cmp++;
        if (fim !== 1'b1 || db_estado !== 4'd8 || botoes !== 4'd0 || db_rodada !== 4'd15) begin
          n_err++;
          $display("FAIL full_run_fim k=%0d got fim=%b estado=%0d b=%b r=%0d want 1/8/0000/15",
                   k, fim, db_estado, botoes, db_rodada);
        end
      end
      if (k == 400) habilitar = 1'b0;
      if (k == 1800) habilitar = 1'b1;
    end
    habilitar = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (db_estado !== 4'd0 || fim !== 1'b0) begin
      n_err++;
      $display("FAIL full_run_ocioso got estado=%0d fim=%b want 0/0", db_estado, fim);
    end
  endtask

  initial begin
    test_reset();
    test_first_rounds();
    test_abort();
    test_noise_and_reset();
    test_full_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
